// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small transmit FIFO; frames go out back to back while data is queued.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_fifo #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] wr_data,
  input  logic            parity_odd,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  // Handshake: a word is accepted on any rising edge with wr_en = 1 and full = 0;
  // writes while full are discarded, there is no back-pressure beyond the full flag.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            par_q, par_d;

  logic [DBIT-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            push, pop, load, done;

  assign push = wr_en && !full_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    load    = 1'b0;
    pop     = 1'b0;
    done    = 1'b0;
    // tx is registered from the current state, so the line follows the FSM by one clk.
    case (state_q)
      IDLE: load = !empty_q;
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (tick_q == TW'(OVS - 1)) begin
            tick_d  = '0;
            state_d = DATA;
          end else tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (s_tick) begin
          if (tick_q == TW'(OVS - 1)) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BW'(DBIT - 1)) begin
              bit_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else bit_d = bit_q + BW'(1);
          end else tick_d = tick_q + TW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = par_q;
        if (s_tick) begin
          if (tick_q == TW'(OVS - 1)) begin
            tick_d  = '0;
            state_d = STOP;
          end else tick_d = tick_q + TW'(1);
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            done    = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
            load    = !empty_q;
          end else tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Shared frame launch from IDLE or straight out of STOP for back-to-back frames.
    if (load) begin
      pop     = 1'b1;
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ parity_odd;
      tick_d  = '0;
      bit_d   = '0;
      state_d = START;
    end
  end

`ifndef UART_TX_PARITY_EN
  logic unused_par;
  assign unused_par = par_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign busy         = (state_q != IDLE);
  assign tx_done_tick = done;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a tick-counting line receiver decodes every frame and
// checks it against a queue of words the FIFO is expected to accept.
module tb_uart_tx_fifo;

  localparam int DBIT       = 8;
  localparam int OVS        = 16;
  localparam int SB_TICK    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB          = 1 + DBIT + P;
  localparam int FRAME_TICKS = OVS * NB + SB_TICK;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_tick = 1'b0;
  logic            wr_en = 1'b0;
  logic [DBIT-1:0] wr_data = '0;
  logic            parity_odd = 1'b0;
  logic            full, empty, busy, tx_done_tick, tx;

  logic [DBIT-1:0] exp_q[$];
  logic            exp_par_q[$];
  logic [DBIT-1:0] bw [6];
  int              n_cmp = 0;
  int              n_err = 0;
  bit              tick_every = 1'b1;

  uart_tx_fifo #(
    .DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .wr_en(wr_en), .wr_data(wr_data),
    .parity_odd(parity_odd), .full(full), .empty(empty), .busy(busy),
    .tx_done_tick(tx_done_tick), .tx(tx)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_tick = tick_every ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // line receiver: counts s_tick pulses from the start of START and samples mid-bit
  int              mon_ticks = 0;
  int              k;
  int              gap_cnt = 0;
  bit              mon_on = 1'b0;
  bit              prev_tick = 1'b0;
  logic [DBIT-1:0] mon_word = '0;
  logic            mon_par = 1'b0;
  logic            ep;

  always @(negedge clk) begin
    if (rst) begin
      mon_on    = 1'b0;
      gap_cnt   = 0;
      prev_tick = 1'b0;
    end else begin
      if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) chk("b2b_start", 32'(tx), 32'd0);
      end
      if (!mon_on && tx == 1'b0) begin
        mon_on    = 1'b1;
        mon_ticks = int'(prev_tick);
        mon_word  = '0;
        mon_par   = 1'b0;
      end
      if (mon_on && s_tick) begin
        mon_ticks++;
        if (mon_ticks < OVS * NB && (mon_ticks % OVS) == OVS / 2) begin
          k = mon_ticks / OVS;
          if (k == 0) chk("start_bit", 32'(tx), 32'd0);
          else if (k <= DBIT) mon_word[k-1] = tx;
          else mon_par = tx;
        end
        if (mon_ticks == OVS * NB + SB_TICK / 2) chk("stop_bit", 32'(tx), 32'd1);
      end
      if (tx_done_tick) begin
        chk("done_in_frame", 32'(mon_on), 32'd1);
        if (mon_on) begin
          chk("frame_ticks", 32'(mon_ticks), 32'(FRAME_TICKS));
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("frame_data", 32'(mon_word), 32'(exp_q.pop_front()));
            ep = exp_par_q.pop_front();
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(mon_par), 32'(ep));
`endif
          end
          gap_cnt = (exp_q.size() > 0) ? 2 : 0;
          mon_on  = 1'b0;
        end
      end
      prev_tick = s_tick;
    end
  end

  // driver: writes bw[0..len-1] on consecutive clks; the first is popped at once,
  // the next FIFO_DEPTH are queued, the rest are dropped
  task automatic send_burst(input int len, input logic odd);
    int acc;
    parity_odd = odd;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      wr_en   = 1'b1;
      wr_data = bw[i];
      if (i < 1 + FIFO_DEPTH) begin
        exp_q.push_back(bw[i]);
        exp_par_q.push_back((^bw[i]) ^ odd);
      end
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    acc = (len < 1 + FIFO_DEPTH) ? len : 1 + FIFO_DEPTH;
    chk("burst_full", 32'(full), 32'(acc - 1 == FIFO_DEPTH));
    chk("burst_empty", 32'(empty), 32'(acc == 1));
    chk("burst_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(exp_q.size() == 0 && !busy), 32'd1);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_full", 32'(full), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done_tick), 32'd0);

    // single 0x55 frame
    bw[0] = 8'h55;
    send_burst(1, 1'b0);
    wait_idle(2000);

    // parity: 0x07 even then odd
    bw[0] = 8'h07;
    send_burst(1, 1'b0);
    wait_idle(2000);
    send_burst(1, 1'b1);
    wait_idle(2000);

    // three back-to-back frames
    bw[0] = 8'h01; bw[1] = 8'h02; bw[2] = 8'h03;
    send_burst(3, 1'b0);
    wait_idle(4000);

    // overfill: 6 writes, 5 accepted
    for (int i = 0; i < 6; i++) bw[i] = 8'(8'hC0 + i);
    send_burst(6, 1'b1);
    wait_idle(6000);

    // reset in the middle of data bit 3 with a second word queued
    bw[0] = 8'h3C; bw[1] = 8'h99;
    send_burst(2, 1'b0);
    repeat (70) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_done", 32'(tx_done_tick), 32'd0);
    exp_q.delete();
    exp_par_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_tx", 32'(tx), 32'd1);
    bw[0] = 8'hA5;
    send_burst(1, 1'b0);
    wait_idle(2000);

    // randomized bursts with dense or sparse s_tick
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < 6; i++) bw[i] = DBIT'($urandom);
      tick_every = 1'($urandom_range(0, 1));
      send_burst(len, 1'($urandom_range(0, 1)));
      wait_idle(8000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
